fixed_to_float_conv: RTL and testbench
======================================

// Module: fixed_to_float_conv
// PURPOSE
//  Sequential converter from 16-bit unsigned 8.8 fixed point (IIIIIIII.FFFFFFFF)
//  to IEEE 754 binary16 (SEEEEEFFFFFFFFFF, bias 15). It sits directly upstream of
//  the float multiplier, so fixed-point operands can be fed into the float datapath.
//  Normalisation is iterative: one left shift per clock. Valid/ready on both sides.
// PARAMETERS
//  ROUND_NEAREST  1  1: round-to-nearest-even on dropped bits; 0: truncate
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   in_data valid
//  in_ready   out  1   converter can accept (state IDLE)
//  in_data    in   16  unsigned 8.8 fixed operand
//  out_valid  out  1   result/inexact valid
//  out_ready  in   1   consumer accepts result
//  result     out  16  binary16 value, sign always 0
//  inexact    out  1   1 if nonzero bits were dropped (before rounding)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; out_valid=0, result=16'h0000, inexact=0;
//   in_ready=1 once in IDLE. Any in-flight conversion is discarded, no output.
//  in_ready = (state==IDLE), combinational from state only. No pass-through.
//  States:
//   IDLE: on in_valid&&in_ready, latch mant<=in_data, exp<=5'd22 -> NORM.
//         in_data==0 -> DONE next edge with result 0x0000, inexact 0.
//   NORM: if mant[15]==1, compute the result, register it, -> DONE.
//         else mant<=mant<<1, exp<=exp-1, stay in NORM.
//   DONE: out_valid=1, result/inexact held stable until out_valid&&out_ready,
//         then -> IDLE (out_valid=0 next cycle).
//  Latency: with p = index of the MSB set in in_data, out_valid rises on the
//   (16-p)th edge after the accepting edge: 1 edge for 0x8000, 16 for 0x0001.
//   Zero input: 1 edge.
//  Exponent = p+7 (range 7..22). No overflow or subnormal output is possible.
//  Result fields: frac = mant[14:5]; G = mant[4]; S = |mant[3:0]; inexact = G|S.
//  ROUND_NEAREST=1: round up iff G && (S || frac[0]). frac carry-out (all ones)
//   -> frac=0, exp+1 (max 23). ROUND_NEAREST=0: frac truncated.
//  While in NORM/DONE, in_valid/in_data are ignored (not sampled).
//  Held output: out_valid stays high with out_ready low for any number of cycles.
//  Back-to-back: after out handshake, the next accept is no earlier than the
//   following cycle.
// TESTING
//  1. Reset mid-NORM (in_data 0x0001, rst_n low at cycle 5) -> out_valid 0 and
//     in_ready 1 immediately; no stray result after release.
//  2. Input 0x0100 -> 0x3C00, inexact 0, in 8 edges. 0x0180 -> 0x3E00.
//     0x0001 -> 0x1C00 in 16 edges. 0x8000 -> 0x5800 in 1 edge.
//  3. Input 0x0000 -> result 0x0000, inexact 0, out_valid after 1 edge.
//  4. Rounding: 0xFFFF -> 0x5C00 (RNE), 0x5BFF (trunc), inexact 1;
//     0x0803 -> 0x4802 (RNE), 0x4801 (trunc), inexact 1.
//  5. Backpressure: out_ready low for 10 cycles -> result stable; in_ready stays 0;
//     in_data changes ignored; single handshake, then in_ready=1.
//  6. Random stream, random valid/ready: compare against a reference model
//     (real-valued conversion + RNE); check count in = count out and order.

Source files
------------

// File: rtl/fixed_to_float_conv.sv
// -----------------------------------------------------------------------------
// fixed_to_float_conv
//
// Converts an unsigned 8.8 fixed-point operand (IIIIIIII.FFFFFFFF) into an
// IEEE 754 binary16 value (SEEEEEFFFFFFFFFF, bias 15) so fixed-point operands
// can enter the float multiplier datapath. Normalisation is iterative: the
// mantissa is shifted left one bit per clock until its MSB is set. Because the
// input is unsigned and at most 16 bits wide, the sign is always 0. The output
// can never overflow and can never be subnormal.
//
// Parameters
//   ROUND_NEAREST  1: round-to-nearest-even on the dropped bits, 0: truncate
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous reset, active low
//   in_valid   in   1   in_data is valid
//   in_ready   out  1   converter can accept an operand (idle)
//   in_data    in   16  unsigned 8.8 fixed-point operand
//   out_valid  out  1   result and inexact are valid
//   out_ready  in   1   consumer accepts the result
//   result     out  16  binary16 value
//   inexact    out  1   nonzero bits were dropped (evaluated before rounding)
// -----------------------------------------------------------------------------
module fixed_to_float_conv #(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    // An operand whose MSB already sits in bit 15 has value 2^7 * 1.f,
    // which gives a biased exponent of 7 + 15 = 22.
    localparam logic [4:0] EXP_START = 5'd22;

    state_t      state;
    state_t      state_next;
    logic [15:0] mant;
    logic [15:0] mant_next;
    logic [4:0]  exponent;
    logic [4:0]  exponent_next;
    logic [15:0] result_reg;
    logic [15:0] result_next;
    logic        inexact_reg;
    logic        inexact_next;

    logic [9:0]  frac_trunc;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [10:0] frac_sum;
    logic [4:0]  exponent_rounded;
    logic [15:0] packed_result;

    // Field extraction from the normalised mantissa. Bit 15 is the hidden
    // leading one, the next ten bits are the stored fraction, and the
    // remaining five bits are what gets dropped.
    assign frac_trunc = mant[14:5];
    assign guard      = mant[4];
    assign sticky     = |mant[3:0];

    // A fraction of all ones that rounds up carries into the exponent. The
    // fraction field then wraps to zero, which is the correct encoding of
    // the next power of two.
    assign round_up         = ROUND_NEAREST ? (guard && (sticky || frac_trunc[0])) : 1'b0;
    assign frac_sum         = {1'b0, frac_trunc} + {10'd0, round_up};
    assign exponent_rounded = exponent + {4'd0, frac_sum[10]};
    assign packed_result    = {1'b0, exponent_rounded, frac_sum[9:0]};

    // The handshake flags depend on the state alone, so there is never a
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_reg;
    assign inexact   = inexact_reg;

    // State register. Reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. The result registers are only loaded when a
    // conversion finishes, so they stay stable throughout backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant        <= 16'h0000;
            exponent    <= 5'd0;
            result_reg  <= 16'h0000;
            inexact_reg <= 1'b0;
        end else begin
            mant        <= mant_next;
            exponent    <= exponent_next;
            result_reg  <= result_next;
            inexact_reg <= inexact_next;
        end
    end

    // Next-state and datapath control. Inputs are only looked at while idle.
    // A zero operand takes one pass through NORM so that its latency matches
    // that of an already-normalised operand, and it never enters the shift
    // loop, which would otherwise never terminate.
    always_comb begin
        state_next    = state;
        mant_next     = mant;
        exponent_next = exponent;
        result_next   = result_reg;
        inexact_next  = inexact_reg;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    mant_next     = in_data;
                    exponent_next = EXP_START;
                    state_next    = NORM;
                end
            end

            NORM: begin
                if (mant == 16'h0000) begin
                    result_next  = 16'h0000;
                    inexact_next = 1'b0;
                    state_next   = DONE;
                end else if (mant[15]) begin
                    result_next  = packed_result;
                    inexact_next = guard | sticky;
                    state_next   = DONE;
                end else begin
                    // At most 15 shifts are needed, so the exponent stays >= 7.
                    mant_next     = {mant[14:0], 1'b0};
                    exponent_next = exponent - 5'd1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fixed_to_float_conv.sv
// -----------------------------------------------------------------------------
// tb_fixed_to_float_conv
//
// Bench for fixed_to_float_conv in round-to-nearest-even mode. Expected
// results are queued when an operand is issued. A separate monitor pops the
// queue and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_fixed_to_float_conv;

    localparam bit ROUND_NEAREST = 1'b1;

    typedef struct packed {
        logic [15:0] res;
        logic        inx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        inexact;

    int   tests;
    int   fails;
    int   n_in;
    int   n_out;
    bit   stop_consumer;
    exp_t sb_q[$];
    exp_t mon_e;

    fixed_to_float_conv #(
        .ROUND_NEAREST(ROUND_NEAREST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .inexact  (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one comparison and report it if it does not match.
    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Record a comparison that fails outright (for example, an expired wait).
    task automatic failNow(input string name, input string what);
        tests++;
        fails++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Reference conversion done with integer arithmetic on the exact value.
    // For an MSB at position p, the significand in units of 2^-10 is
    // d * 2^(10 - p). The remainder of that division decides the rounding.
    function automatic exp_t refConv(input logic [15:0] d);
        int     p;
        int     e5;
        longint num;
        longint q;
        longint rem;
        longint half;
        exp_t   r;
        r = '0;
        if (d == 16'h0000) return r;
        p = 0;
        for (int i = 0; i < 16; i++) if (d[i]) p = i;
        num  = longint'(d) << 10;
        q    = num >> p;
        rem  = num - (q << p);
        half = (p > 0) ? (longint'(1) << (p - 1)) : 0;
        r.inx = (rem != 0);
        if (ROUND_NEAREST && p > 0 && (rem > half || (rem == half && (q % 2) == 1))) q++;
        e5 = p + 7;
        if (q == 2048) begin
            q  = 1024;
            e5 = e5 + 1;
        end
        r.res = {1'b0, e5[4:0], q[9:0]};
        return r;
    endfunction

    // Monitor: each output handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                failNow("unexpected_output", $sformatf("got result %h with nothing expected", result));
            end else begin
                mon_e = sb_q.pop_front();
                check16("result", result, mon_e.res);
                check16("inexact", {15'd0, inexact}, {15'd0, mon_e.inx});
            end
        end
    end

    // Issue one operand and measure the edges from acceptance to out_valid.
    // out_ready is held low, so the result stays presented afterwards.
    task automatic applyStimulus(input logic [15:0] data, input logic [15:0] exp_res,
                                 input logic exp_inx, input int exp_lat);
        int   waitc;
        int   lat;
        exp_t e;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!in_ready) begin
            failNow("accept_timeout", "in_ready never rose");
            return;
        end
        in_valid = 1'b1;
        in_data  = data;
        e.res    = exp_res;
        e.inx    = exp_inx;
        sb_q.push_back(e);
        n_in++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check16($sformatf("latency_%h", data), lat[15:0], exp_lat[15:0]);
    endtask

    // Release the presented result and check that the converter is idle
    // again on the following cycle.
    task automatic checkOutput();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check16("out_valid_after_hs", {15'd0, out_valid}, 16'd0);
        check16("in_ready_after_hs", {15'd0, in_ready}, 16'd1);
    endtask

    initial begin : main
        int   out_before;
        int   w;
        bit   accepted;
        logic [15:0] d;

        tests         = 0;
        fails         = 0;
        n_in          = 0;
        n_out         = 0;
        stop_consumer = 1'b0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = 16'h0000;
        out_ready     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check16("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check16("reset_in_ready", {15'd0, in_ready}, 16'd1);
        check16("reset_result", result, 16'h0000);
        check16("reset_inexact", {15'd0, inexact}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors (round to nearest even)
        applyStimulus(16'h0100, 16'h3C00, 1'b0, 8);  checkOutput();
        applyStimulus(16'h0001, 16'h1C00, 1'b0, 16); checkOutput();
        applyStimulus(16'h8000, 16'h5800, 1'b0, 1);  checkOutput();
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1);  checkOutput();
        applyStimulus(16'hFFFF, 16'h5C00, 1'b1, 1);  checkOutput();
        applyStimulus(16'h0803, 16'h4802, 1'b1, 5);  checkOutput();
        applyStimulus(16'h0FFF, 16'h4C00, 1'b1, 5);  checkOutput();
        applyStimulus(16'h0811, 16'h4808, 1'b1, 5);  checkOutput();

        // Backpressure: the result holds and new inputs are ignored.
        applyStimulus(16'h0180, 16'h3E00, 1'b0, 8);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk);
            #1;
            check16("bp_result", result, 16'h3E00);
            check16("bp_in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid = 1'b0;
        checkOutput();

        // Reset in the middle of a long normalisation.
        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_before = n_out;
        rst_n = 1'b0;
        #1;
        check16("midreset_out_valid", {15'd0, out_valid}, 16'd0);
        check16("midreset_in_ready", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check16("midreset_no_output", 16'(n_out - out_before), 16'd0);

        // Random stream with random valid/ready against the reference model.
        fork
            begin : producer
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 3))
                        0: d = 16'($urandom);
                        1: d = (16'h0001 << $urandom_range(0, 15)) | 16'($urandom_range(0, 7));
                        2: d = 16'($urandom_range(0, 255));
                        default: d = 16'hFFFF - 16'($urandom_range(0, 31));
                    endcase
                    in_valid = 1'b1;
                    in_data  = d;
                    accepted = 1'b0;
                    w = 0;
                    while (!accepted && w < 200) begin
                        @(negedge clk);
                        if (in_ready) begin
                            accepted = 1'b1;
                            sb_q.push_back(refConv(d));
                            n_in++;
                        end
                        @(posedge clk);
                        #1;
                        w++;
                    end
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    if (!accepted) begin
                        failNow("random_accept_timeout", "operand never accepted");
                        break;
                    end
                end
                w = 0;
                while (sb_q.size() != 0 && w < 3000) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (sb_q.size() != 0) failNow("drain_timeout", $sformatf("%0d results still pending", sb_q.size()));
                stop_consumer = 1'b1;
            end
            begin : consumer
                while (!stop_consumer) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
            end
        join

        check16("count_in_vs_out", 16'(n_out), 16'(n_in));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
